// File: rtl/rv32i_types.sv
// Shared RV32I type definitions: opcodes, immediate formats and decode-queue entries.
package rv32i_types;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PC_MAX_W = 32;  // widest PC a queue entry can hold

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BR     = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_OP_IMM = 7'b0010011,
    OP_OP     = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    logic [XLEN-1:0]     inst;
    logic [PC_MAX_W-1:0] pc;
    imm_fmt_t            fmt;
    logic [XLEN-1:0]     imm;
  } dq_entry_t;

endpackage

// File: rtl/inst_predecode.sv
// Combinational pre-decode: picks the immediate format from the opcode and builds the immediate.
module inst_predecode
  import rv32i_types::*;
(
  input  logic [31:0] inst_i,
  output imm_fmt_t    fmt_o,
  output logic [31:0] imm_o
);

  // Format select and sign-extended immediate assembly
  always_comb begin
    fmt_o = FMT_NONE;
    imm_o = '0;
    case (inst_i[6:0])
      OP_LUI, OP_AUIPC: begin
        fmt_o = FMT_U;
        imm_o = {inst_i[31:12], 12'h000};
      end
      OP_JAL: begin
        fmt_o = FMT_J;
        imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_OP_IMM: begin
        fmt_o = FMT_I;
        imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OP_STORE: begin
        fmt_o = FMT_S;
        imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      OP_BR: begin
        fmt_o = FMT_B;
        imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      end
      default: begin
        fmt_o = FMT_NONE;
        imm_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// FIFO of pre-decoded instructions feeding the issue stage; flush empties it for redirects.
module decode_queue
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 4,   // power of two, >= 2
  parameter int unsigned PC_W  = 32   // must not exceed PC_MAX_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [31:0]                enq_inst,
  input  logic [PC_W-1:0]            enq_pc,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [31:0]                deq_inst,
  output logic [PC_W-1:0]            deq_pc,
  output logic [6:0]                 deq_opcode,
  output logic [2:0]                 deq_funct3,
  output logic [6:0]                 deq_funct7,
  output logic [4:0]                 deq_rs1_s,
  output logic [4:0]                 deq_rs2_s,
  output logic [4:0]                 deq_rd_s,
  output logic [31:0]                deq_imm,
  output logic [2:0]                 deq_fmt,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  dq_entry_t              mem_q [DEPTH];
  logic      [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic      [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic      [CNT_W-1:0]  count_q,  count_d;

  imm_fmt_t    pd_fmt;
  logic [31:0] pd_imm;
  dq_entry_t   enq_entry;
  dq_entry_t   head;
  logic        enq_fire;
  logic        deq_fire;

  inst_predecode u_predecode (
    .inst_i (enq_inst),
    .fmt_o  (pd_fmt),
    .imm_o  (pd_imm)
  );

  // Handshake flags come straight from the occupancy register
  assign enq_ready = (count_q != CNT_W'(DEPTH));
  assign deq_valid = (count_q != '0);
  assign count     = count_q;

  // Flush wins over both handshakes in the same cycle
  assign enq_fire  = enq_valid && enq_ready && !flush;
  assign deq_fire  = deq_valid && deq_ready && !flush;

  // Entry written on enqueue, built from the pre-decoder outputs
  always_comb begin
    enq_entry      = '0;
    enq_entry.inst = enq_inst;
    enq_entry.pc   = PC_MAX_W'(enq_pc);
    enq_entry.fmt  = pd_fmt;
    enq_entry.imm  = pd_imm;
  end

  // Next-state for pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (enq_fire && !deq_fire) count_d = count_q + CNT_W'(1);
      if (deq_fire && !enq_fire) count_d = count_q - CNT_W'(1);
    end
  end

  // State and storage registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (enq_fire) mem_q[wr_ptr_q] <= enq_entry;
    end
  end

  // Head entry fields, forced to zero while the queue is empty
  always_comb begin
    head       = mem_q[rd_ptr_q];
    deq_inst   = '0;
    deq_pc     = '0;
    deq_opcode = '0;
    deq_funct3 = '0;
    deq_funct7 = '0;
    deq_rs1_s  = '0;
    deq_rs2_s  = '0;
    deq_rd_s   = '0;
    deq_imm    = '0;
    deq_fmt    = '0;
    if (deq_valid) begin
      deq_inst   = head.inst;
      deq_pc     = PC_W'(head.pc);
      deq_opcode = head.inst[6:0];
      deq_funct3 = head.inst[14:12];
      deq_funct7 = head.inst[31:25];
      deq_rs1_s  = head.inst[19:15];
      deq_rs2_s  = head.inst[24:20];
      deq_rd_s   = head.inst[11:7];
      deq_imm    = head.imm;
      deq_fmt    = head.fmt;
    end
  end

endmodule
